// File: rtl/isqrt_dual_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : isqrt_dual_scheduler
// Description : Two-slot in-order dispatcher that feeds two isqrt units
//               alternately and returns their results in acceptance order.
// Revision    : 1.0 - initial release
// ============================================================================
module isqrt_dual_scheduler #(
    parameter int X_W = 32,
    parameter int Y_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           x_vld,
    output logic           x_rdy,
    input  logic [X_W-1:0] x,
    output logic           y_vld,
    input  logic           y_rdy,
    output logic [Y_W-1:0] y,
    output logic           isqrt_1_x_vld,
    output logic [X_W-1:0] isqrt_1_x,
    input  logic           isqrt_1_y_vld,
    input  logic [Y_W-1:0] isqrt_1_y,
    output logic           isqrt_2_x_vld,
    output logic [X_W-1:0] isqrt_2_x,
    input  logic           isqrt_2_y_vld,
    input  logic [Y_W-1:0] isqrt_2_y,
    output logic [1:0]     busy_cnt,
    output logic           err
);

    typedef enum logic [1:0] {
        SLOT_IDLE = 2'd0,
        SLOT_BUSY = 2'd1,
        SLOT_DONE = 2'd2
    } slot_e;

    slot_e          slot_q [2];
    slot_e          slot_d [2];
    logic [Y_W-1:0] res_q  [2];
    logic [Y_W-1:0] res_d  [2];
    logic [X_W-1:0] ux_q   [2];
    logic [X_W-1:0] ux_d   [2];
    logic [1:0]     ux_vld_q, ux_vld_d;
    logic           iss_ptr_q, iss_ptr_d;
    logic           ret_ptr_q, ret_ptr_d;
    logic [1:0]     busy_q, busy_d;
    logic           err_q, err_d;

    logic [1:0]     w_uy_vld;
    logic [Y_W-1:0] w_uy [2];
    logic           w_accept;
    logic           w_drain;

    assign w_uy_vld = {isqrt_2_y_vld, isqrt_1_y_vld};
    assign w_uy[0]  = isqrt_1_y;
    assign w_uy[1]  = isqrt_2_y;

    // Handshake flags come from registered slot state only.
    assign x_rdy    = (slot_q[iss_ptr_q] == SLOT_IDLE);
    assign y_vld    = (slot_q[ret_ptr_q] == SLOT_DONE);
    assign y        = res_q[ret_ptr_q];
    assign w_accept = x_vld && x_rdy;
    assign w_drain  = y_vld && y_rdy;

    assign isqrt_1_x_vld = ux_vld_q[0];
    assign isqrt_2_x_vld = ux_vld_q[1];
    assign isqrt_1_x     = ux_q[0];
    assign isqrt_2_x     = ux_q[1];
    assign busy_cnt      = busy_q;
    assign err           = err_q;

    always_comb begin
        slot_d    = slot_q;
        res_d     = res_q;
        ux_d      = ux_q;
        ux_vld_d  = 2'b00;
        iss_ptr_d = iss_ptr_q;
        ret_ptr_d = ret_ptr_q;
        err_d     = err_q;

        // A return only lands on a BUSY slot; anything else is a protocol error.
        for (int k = 0; k < 2; k++) begin
            if (w_uy_vld[k]) begin
                if (slot_q[k] == SLOT_BUSY) begin
                    slot_d[k] = SLOT_DONE;
                    res_d[k]  = w_uy[k];
                end else begin
                    err_d = 1'b1;
                end
            end
        end

        if (w_accept) begin
            slot_d[iss_ptr_q]   = SLOT_BUSY;
            ux_vld_d[iss_ptr_q] = 1'b1;
            ux_d[iss_ptr_q]     = x;
            iss_ptr_d           = ~iss_ptr_q;
        end

        if (w_drain) begin
            slot_d[ret_ptr_q] = SLOT_IDLE;
            ret_ptr_d         = ~ret_ptr_q;
        end

        busy_d = {1'b0, slot_d[0] != SLOT_IDLE} + {1'b0, slot_d[1] != SLOT_IDLE};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                slot_q[k] <= SLOT_IDLE;
                res_q[k]  <= '0;
                ux_q[k]   <= '0;
            end
            ux_vld_q  <= 2'b00;
            iss_ptr_q <= 1'b0;
            ret_ptr_q <= 1'b0;
            busy_q    <= 2'd0;
            err_q     <= 1'b0;
        end else begin
            slot_q    <= slot_d;
            res_q     <= res_d;
            ux_q      <= ux_d;
            ux_vld_q  <= ux_vld_d;
            iss_ptr_q <= iss_ptr_d;
            ret_ptr_q <= ret_ptr_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_isqrt_dual_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_isqrt_dual_scheduler
// Description : Directed and randomized bench; the two isqrt units are modelled
//               here, and expectations come from an in-order queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_isqrt_dual_scheduler;
    localparam int X_W = 32;
    localparam int Y_W = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           x_vld = 1'b0;
    logic [X_W-1:0] x = '0;
    logic           y_rdy = 1'b0;
    logic [1:0]     u_vld = 2'b00;
    logic [Y_W-1:0] u_y [2];
    logic           x_rdy, y_vld, i1_x_vld, i2_x_vld, err;
    logic [Y_W-1:0] y;
    logic [X_W-1:0] i1_x, i2_x;
    logic [1:0]     busy_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: outstanding requests in acceptance order.
    logic [X_W-1:0] q_x   [$];
    int             q_u   [$];
    bit             q_done[$];
    logic [Y_W-1:0] q_val [$];
    int             nxt_u = 0;
    int             due   [2] = '{-1, -1};
    logic [Y_W-1:0] dval  [2];
    int             lat   [2] = '{3, 3};
    bit             pulse_e [2] = '{0, 0};
    logic [X_W-1:0] lastx_e [2] = '{0, 0};
    bit             err_e = 0;

    always #5 clk = ~clk;

    isqrt_dual_scheduler #(.X_W(X_W), .Y_W(Y_W)) dut (
        .clk(clk), .rst(rst),
        .x_vld(x_vld), .x_rdy(x_rdy), .x(x),
        .y_vld(y_vld), .y_rdy(y_rdy), .y(y),
        .isqrt_1_x_vld(i1_x_vld), .isqrt_1_x(i1_x),
        .isqrt_1_y_vld(u_vld[0]), .isqrt_1_y(u_y[0]),
        .isqrt_2_x_vld(i2_x_vld), .isqrt_2_x(i2_x),
        .isqrt_2_y_vld(u_vld[1]), .isqrt_2_y(u_y[1]),
        .busy_cnt(busy_cnt), .err(err)
    );

    function automatic logic [Y_W-1:0] ref_isqrt(input logic [X_W-1:0] v);
        logic [63:0] r = 64'd0;
        logic [63:0] t;
        for (int b = Y_W - 1; b >= 0; b--) begin
            t = r + (64'd1 << b);
            if (t * t <= {32'd0, v}) r = t;
        end
        return r[Y_W-1:0];
    endfunction

    task automatic drive_units();
        for (int k = 0; k < 2; k++) begin
            if (due[k] == cyc) begin
                u_vld[k] = 1'b1;
                u_y[k]   = dval[k];
                due[k]   = -1;
            end else begin
                u_vld[k] = 1'b0;
                u_y[k]   = Y_W'($urandom);
            end
        end
    endtask

    // Apply this cycle's handshakes to the model, then move to the next cycle.
    task automatic advance();
        bit acc, drn;
        int idx;
        acc = x_vld && (q_x.size() < 2);
        drn = y_rdy && (q_x.size() > 0) && q_done[0];
        for (int k = 0; k < 2; k++) begin
            if (u_vld[k]) begin
                idx = -1;
                foreach (q_u[i]) if (q_u[i] == k && !q_done[i]) idx = i;
                if (idx >= 0) begin
                    q_done[idx] = 1'b1;
                    q_val[idx]  = u_y[k];
                end else begin
                    err_e = 1'b1;
                end
            end
        end
        pulse_e = '{0, 0};
        if (drn) begin
            void'(q_x.pop_front()); void'(q_u.pop_front());
            void'(q_done.pop_front()); void'(q_val.pop_front());
        end
        if (acc) begin
            q_x.push_back(x); q_u.push_back(nxt_u);
            q_done.push_back(1'b0); q_val.push_back('0);
            pulse_e[nxt_u] = 1'b1;
            lastx_e[nxt_u] = x;
            due[nxt_u]     = cyc + 1 + lat[nxt_u];
            dval[nxt_u]    = ref_isqrt(x);
            nxt_u          = 1 - nxt_u;
        end
        @(negedge clk);
        cyc++;
        drive_units();
    endtask

    task automatic reset_assert();
        #2;
        rst = 1'b0;
    endtask

    // Late unit returns stay scheduled across reset on purpose.
    task automatic reset_release();
        @(negedge clk);
        rst = 1'b1;
        q_x.delete(); q_u.delete(); q_done.delete(); q_val.delete();
        nxt_u   = 0;
        pulse_e = '{0, 0};
        lastx_e = '{0, 0};
        err_e   = 1'b0;
        cyc++;
        drive_units();
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #1;
        checks++; if (busy_cnt !== 2'd0) begin errors++; $display("FAIL reset_busy: got %0d want 0", busy_cnt); end
        checks++; if (y_vld !== 1'b0) begin errors++; $display("FAIL reset_y_vld: got %0b want 0", y_vld); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", err); end
        checks++; if ({i1_x_vld, i2_x_vld} !== 2'b00) begin errors++; $display("FAIL reset_x_vld: got %b want 00", {i1_x_vld, i2_x_vld}); end
        checks++; if (i1_x !== '0 || i2_x !== '0 || y !== '0) begin errors++; $display("FAIL reset_data: got %h %h %h want 0", i1_x, i2_x, y); end
        @(negedge clk);
        reset_release();
        checks++; if (x_rdy !== 1'b1) begin errors++; $display("FAIL reset_x_rdy: got %0b want 1", x_rdy); end
    endtask

    task automatic test_single();
        lat = '{3, 3};
        y_rdy = 1'b1; x_vld = 1'b1; x = 32'd16;
        checks++; if (x_rdy !== 1'b1) begin errors++; $display("FAIL single_x_rdy: got %0b want 1", x_rdy); end
        advance();
        x_vld = 1'b0;
        checks++; if (i1_x_vld !== 1'b1 || i1_x !== 32'd16 || i2_x_vld !== 1'b0) begin
            errors++; $display("FAIL single_issue: got vld1=%0b x1=%0d vld2=%0b want 1 16 0", i1_x_vld, i1_x, i2_x_vld); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (y_vld !== 1'b0) begin errors++; $display("FAIL single_y_early: got %0b want 0 at T+%0d", y_vld, i + 1); end
            if (i > 0) begin
                checks++; if (i1_x_vld !== 1'b0) begin errors++; $display("FAIL single_pulse_len: got %0b want 0 at T+%0d", i1_x_vld, i + 1); end
            end
            advance();
        end
        checks++; if (y_vld !== 1'b1 || y !== 16'd4) begin errors++; $display("FAIL single_result: got vld=%0b y=%0d want 1 4", y_vld, y); end
        advance();
        checks++; if (y_vld !== 1'b0 || busy_cnt !== 2'd0) begin errors++; $display("FAIL single_drain: got vld=%0b busy=%0d want 0 0", y_vld, busy_cnt); end
    endtask

    task automatic test_order();
        logic [Y_W-1:0] got [$];
        lat[nxt_u] = 6; lat[1-nxt_u] = 1;
        y_rdy = 1'b1; x_vld = 1'b1; x = 32'd144;
        advance();
        x = 32'd1;
        advance();
        x_vld = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (y_vld && y_rdy) got.push_back(y);
            advance();
        end
        checks++; if (got.size() != 2) begin errors++; $display("FAIL order_count: got %0d want 2", got.size()); end
        checks++; if (got.size() < 2 || got[0] !== 16'd12 || got[1] !== 16'd1) begin
            errors++; $display("FAIL order_values: got %p want 12 then 1", got); end
    endtask

    task automatic test_backpressure();
        logic [X_W-1:0] vals [3] = '{32'd100, 32'd400, 32'd900};
        logic [Y_W-1:0] got [$];
        int n_acc = 0, first_drain = -1, third_acc = -1;
        lat = '{2, 2};
        y_rdy = 1'b0; x_vld = 1'b1; x = vals[0];
        for (int i = 0; i < 8; i++) begin
            if (x_rdy) n_acc++;
            advance();
            if (n_acc < 3) x = vals[n_acc];
        end
        checks++; if (n_acc != 2) begin errors++; $display("FAIL bp_accepts: got %0d want 2", n_acc); end
        checks++; if (x_rdy !== 1'b0 || busy_cnt !== 2'd2) begin errors++; $display("FAIL bp_full: got rdy=%0b busy=%0d want 0 2", x_rdy, busy_cnt); end
        y_rdy = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (y_vld) begin
                if (first_drain < 0) first_drain = cyc;
                got.push_back(y);
            end
            if (x_vld && x_rdy && third_acc < 0) third_acc = cyc;
            advance();
            if (third_acc >= 0) x_vld = 1'b0;
        end
        checks++; if (first_drain < 0 || third_acc != first_drain + 1) begin
            errors++; $display("FAIL bp_reuse: got accept cycle %0d want %0d", third_acc, first_drain + 1); end
        checks++; if (got.size() != 3 || got[0] !== 16'd10 || got[1] !== 16'd20 || got[2] !== 16'd30) begin
            errors++; $display("FAIL bp_values: got %p want 10 20 30", got); end
    endtask

    task automatic test_same_cycle();
        logic [Y_W-1:0] got [$];
        int c0 = -1, c1 = -1;
        lat[nxt_u] = 2; lat[1-nxt_u] = 1;
        y_rdy = 1'b1; x_vld = 1'b1; x = 32'hFFFF_FFFF;
        advance();
        x = 32'd0;
        advance();
        x_vld = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (y_vld) begin
                got.push_back(y);
                if (c0 < 0) c0 = cyc; else if (c1 < 0) c1 = cyc;
            end
            advance();
        end
        checks++; if (got.size() != 2 || got[0] !== 16'd65535 || got[1] !== 16'd0) begin
            errors++; $display("FAIL same_values: got %p want 65535 then 0", got); end
        checks++; if (c0 < 0 || c1 != c0 + 1) begin errors++; $display("FAIL same_spacing: got cycles %0d %0d want consecutive", c0, c1); end
    endtask

    task automatic test_spurious();
        checks++; if (err !== 1'b0 || busy_cnt !== 2'd0) begin errors++; $display("FAIL spur_pre: got err=%0b busy=%0d want 0 0", err, busy_cnt); end
        u_vld[1] = 1'b1; u_y[1] = 16'h1234;
        advance();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL spur_err: got %0b want 1", err); end
        checks++; if (y_vld !== 1'b0 || busy_cnt !== 2'd0) begin errors++; $display("FAIL spur_state: got vld=%0b busy=%0d want 0 0", y_vld, busy_cnt); end
        for (int i = 0; i < 5; i++) advance();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL spur_sticky: got %0b want 1", err); end
        reset_assert();
        #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL spur_clear: got %0b want 0", err); end
        reset_release();
    endtask

    task automatic test_reset_busy();
        lat = '{2, 2};
        y_rdy = 1'b0; x_vld = 1'b1; x = 32'd49;
        advance();
        x = 32'd81;
        advance();
        x_vld = 1'b0;
        checks++; if (busy_cnt !== 2'd2) begin errors++; $display("FAIL rb_busy: got %0d want 2", busy_cnt); end
        reset_assert();
        #1;
        checks++; if (busy_cnt !== 2'd0 || y_vld !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL rb_async: got busy=%0d vld=%0b err=%0b want 0 0 0", busy_cnt, y_vld, err); end
        checks++; if ({i1_x_vld, i2_x_vld} !== 2'b00 || i1_x !== '0 || i2_x !== '0 || y !== '0) begin
            errors++; $display("FAIL rb_data: got %b %h %h %h want zeros", {i1_x_vld, i2_x_vld}, i1_x, i2_x, y); end
        reset_release();
        for (int i = 0; i < 3; i++) advance();
        checks++; if (err !== 1'b1 || busy_cnt !== 2'd0) begin errors++; $display("FAIL rb_late: got err=%0b busy=%0d want 1 0", err, busy_cnt); end
        x_vld = 1'b1; x = 32'd25;
        checks++; if (x_rdy !== 1'b1) begin errors++; $display("FAIL rb_rdy: got %0b want 1", x_rdy); end
        advance();
        x_vld = 1'b0;
        checks++; if (i1_x_vld !== 1'b1 || i2_x_vld !== 1'b0 || i1_x !== 32'd25) begin
            errors++; $display("FAIL rb_unit1: got vld1=%0b vld2=%0b x1=%0d want 1 0 25", i1_x_vld, i2_x_vld, i1_x); end
        y_rdy = 1'b1;
        for (int i = 0; i < 8; i++) advance();
        reset_assert();
        reset_release();
    endtask

    task automatic test_random();
        bit e_rdy, e_vld;
        for (int n = 0; n < 500; n++) begin
            x_vld = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 5))
                0:       x = '0;
                1:       x = '1;
                default: x = X_W'($urandom);
            endcase
            y_rdy  = ($urandom_range(0, 9) < 6);
            lat[0] = $urandom_range(1, 6);
            lat[1] = $urandom_range(1, 6);
            e_rdy = (q_x.size() < 2);
            e_vld = (q_x.size() > 0) && q_done[0];
            checks++; if (x_rdy !== e_rdy) begin errors++; $display("FAIL rnd_x_rdy cyc %0d: got %0b want %0b", cyc, x_rdy, e_rdy); end
            checks++; if (y_vld !== e_vld) begin errors++; $display("FAIL rnd_y_vld cyc %0d: got %0b want %0b", cyc, y_vld, e_vld); end
            if (e_vld) begin
                checks++; if (y !== q_val[0]) begin errors++; $display("FAIL rnd_y cyc %0d: got %0d want %0d", cyc, y, q_val[0]); end
            end
            checks++; if (busy_cnt !== 2'(q_x.size())) begin errors++; $display("FAIL rnd_busy cyc %0d: got %0d want %0d", cyc, busy_cnt, q_x.size()); end
            checks++; if (err !== err_e) begin errors++; $display("FAIL rnd_err cyc %0d: got %0b want %0b", cyc, err, err_e); end
            checks++; if (i1_x_vld !== pulse_e[0] || i2_x_vld !== pulse_e[1]) begin
                errors++; $display("FAIL rnd_issue cyc %0d: got %0b%0b want %0b%0b", cyc, i1_x_vld, i2_x_vld, pulse_e[0], pulse_e[1]); end
            checks++; if (i1_x !== lastx_e[0] || i2_x !== lastx_e[1]) begin
                errors++; $display("FAIL rnd_unit_x cyc %0d: got %h %h want %h %h", cyc, i1_x, i2_x, lastx_e[0], lastx_e[1]); end
            advance();
        end
        x_vld = 1'b0; y_rdy = 1'b1;
        for (int i = 0; i < 25; i++) advance();
        checks++; if (busy_cnt !== 2'd0 || y_vld !== 1'b0) begin errors++; $display("FAIL rnd_final: got busy=%0d vld=%0b want 0 0", busy_cnt, y_vld); end
    endtask

    initial begin
        u_y[0] = '0;
        u_y[1] = '0;
        test_reset();
        test_single();
        test_order();
        test_backpressure();
        test_same_cycle();
        test_spurious();
        test_reset_busy();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/isqrt_dual_scheduler.md
ISQRT_DUAL_SCHEDULER -- requirements
Module: isqrt_dual_scheduler

Interface
REQ-001 SHALL have parameter X_W, default 32: radicand width.
REQ-002 SHALL have parameter Y_W, default 16: root width; SHALL equal X_W/2.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low (asserted when 0).
REQ-005 SHALL have ports x_vld  input  1 / x_rdy  output  1 / x  input  X_W: request stream.
REQ-006 SHALL have ports y_vld  output  1 / y_rdy  input  1 / y  output  Y_W: in-order result stream.
REQ-007 SHALL have ports isqrt_1_x_vld  output  1 / isqrt_1_x  output  X_W / isqrt_1_y_vld  input  1 / isqrt_1_y  input  Y_W: unit 1.
REQ-008 SHALL have the same four ports with prefix isqrt_2_: unit 2.
REQ-009 SHALL have port busy_cnt  output  2  slots not IDLE (0..2).
REQ-010 SHALL have port err  output  1  sticky protocol-error flag.

Function
REQ-011 SHALL keep one slot per unit, state IDLE, BUSY or DONE, plus Y_W-bit result register.
REQ-012 SHALL keep 1-bit iss_ptr and ret_ptr; value 0 selects unit 1, 1 selects unit 2.
REQ-013 SHALL drive x_rdy = 1 exactly when slot[iss_ptr] is IDLE, from registered state only.
REQ-014 On x_vld && x_rdy (accept, cycle T): slot[iss_ptr] IDLE->BUSY, iss_ptr toggles, x registered.
REQ-015 SHALL pulse isqrt_k_x_vld for exactly one cycle, T+1, with isqrt_k_x = accepted x; isqrt_k_x_vld SHALL be 0 in every other cycle.
REQ-016 isqrt_k_x SHALL hold its last value when isqrt_k_x_vld is 0.
REQ-017 On isqrt_k_y_vld with slot k BUSY: capture isqrt_k_y, slot k BUSY->DONE next edge.
REQ-018 isqrt_k_y_vld with slot k IDLE or DONE SHALL be ignored (no state/data change) and SHALL set err.
REQ-019 Both units returning in the same cycle SHALL both be captured independently.
REQ-020 SHALL drive y_vld = 1 exactly when slot[ret_ptr] is DONE; y = result[ret_ptr].
REQ-021 On y_vld && y_rdy: slot[ret_ptr] DONE->IDLE, ret_ptr toggles.
REQ-022 While y_vld && !y_rdy, y and y_vld SHALL remain stable.
REQ-023 Results SHALL leave in acceptance order regardless of which unit finishes first.
REQ-024 A slot freed by drain in cycle C SHALL be acceptable no earlier than C+1 (no same-cycle reuse).
REQ-025 With unit latency L (x_vld to y_vld), y_vld SHALL first rise at T+2+L.
REQ-026 Sustained throughput with y_rdy = 1 SHALL be two accepts per L+3 cycles.
REQ-027 busy_cnt SHALL equal registered count of BUSY plus DONE slots.
REQ-028 err SHALL stay 1 until reset once set.

Reset
REQ-029 On rst = 0, asynchronously: slots IDLE, iss_ptr = ret_ptr = 0, results and isqrt_k_x = 0, isqrt_k_x_vld = 0, y_vld = 0, busy_cnt = 0, err = 0; x_rdy = 1 after release.
REQ-030 Reset mid-operation SHALL discard all in-flight work; unit results arriving after release SHALL be handled per REQ-018.
REQ-031 First accept after release SHALL be issued to unit 1.

Verification
REQ-032 x = 16 accepted, unit 1 returns 4 after L = 3 -> isqrt_1_x_vld at T+1, y = 4 with y_vld at T+5.
REQ-033 Back-to-back x = 144 then x = 1; unit 2 returns 1 before unit 1 returns 12 -> output order 12, then 1.
REQ-034 y_rdy = 0, three requests offered -> two accepted, x_rdy = 0, busy_cnt = 2; y_rdy = 1 -> drains 2 results, third accepted a cycle after first drain.
REQ-035 isqrt_2_y_vld pulse with no request outstanding -> err = 1, y_vld stays 0, busy_cnt stays 0.
REQ-036 x = 0xFFFFFFFF and x = 0 back-to-back, both units return same cycle -> y = 65535 then 0.
REQ-037 rst = 0 while busy_cnt = 2 -> all outputs zero immediately; after release next accept goes to unit 1.
